rtd_stimulus: RTL and testbench
===============================

Name: rtd_stimulus

Overview:
- Stimulus generator for the reaction-time detector: the initiator side of the `w`/`bt` interface.
- On an arm request it waits a pseudo-random delay, then issues the one-cycle `w` pulse that lights the reaction LED and starts the BCD timer.
- It supervises the player's button: an early press is a false start, a press after `w` is a valid response, no press is a timeout.
- Sits between the board buttons and the detector, on the same 100 MHz `clk`.

Parameters:
- TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz -> 1 kHz).
- MIN_DELAY_MS, 1000, fixed part of the stimulus delay in ms.
- RANGE_BITS, 11, width of the random part; delay = MIN_DELAY_MS + lfsr[RANGE_BITS-1:0] ms.
- TIMEOUT_MS, 2000, ms allowed after `w` before the trial is abandoned.
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  arm button, active-high, asynchronous to clk
- bt  in  1  reaction button, active-low (0 = pressed), asynchronous to clk
- w  out  1  stimulus pulse to the detector, exactly one clk wide
- busy  out  1  high in WAIT, FIRE and HOLD
- false_start  out  1  sticky flag, high in FAULT
- done  out  1  one-cycle pulse on a valid response
- timeout  out  1  one-cycle pulse when TIMEOUT_MS expires
- cur_delay  out  16  delay in ms loaded for the current trial (debug/verification)
- state  out  3  encoded FSM state: IDLE=0, WAIT=1, FIRE=2, HOLD=3, FAULT=4

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, w=0, busy=0, false_start=0, done=0, timeout=0, cur_delay=0;
  - prescaler=0, ms counter=0, lfsr=LFSR_SEED, synchronizer flops cleared.
- Reset mid-trial aborts the trial immediately; no `w` is emitted after release until a new start.
- Input conditioning:
  - start and bt each pass through a 2-flop synchronizer.
  - start_rise = synced start 1 now and 0 in the previous cycle. Input-to-action latency is 3 cycles.
  - pressed = synced bt == 0, sampled as a level.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1; advances every clk cycle, including in IDLE; never 0.
- ms tick: prescaler counts 0..TICK_DIV-1; tick when it wraps. The prescaler and ms counter are cleared on every state entry, so a delay of N ms is exactly N*TICK_DIV cycles.
- IDLE:
  - On start_rise with pressed=0: load cur_delay = MIN_DELAY_MS + lfsr[RANGE_BITS-1:0] and go to WAIT.
  - On start_rise with pressed=1: stay in IDLE (request ignored).
- WAIT:
  - If pressed is seen in any cycle: go to FAULT and set false_start. Pressed wins over a coincident delay expiry.
  - Else when the ms counter reaches cur_delay: go to FIRE.
  - start_rise is ignored.
- FIRE: w=1 for this single cycle, then go to HOLD unconditionally.
- HOLD:
  - If pressed: done=1 for one cycle, go to IDLE.
  - Else when the ms counter reaches TIMEOUT_MS: timeout=1 for one cycle, go to IDLE.
  - A press coincident with expiry counts as done.
  - start_rise is ignored.
- FAULT:
  - false_start stays high; w stays 0.
  - start_rise with pressed=0: clear false_start, load a new cur_delay, go to WAIT.
  - start_rise with pressed=1: stay in FAULT.
- busy is combinational from state. w, done and timeout are registered and glitch-free.
- cur_delay holds its value until the next load (not cleared on return to IDLE).
- Widths:
  - Ms counter is 16-bit and saturates at 16'hFFFF.
  - MIN_DELAY_MS + 2^RANGE_BITS - 1 and TIMEOUT_MS must both be <= 65535. This is checked by an elaboration assertion.

Test Plan:
Unless stated otherwise, the bench uses TICK_DIV=4, MIN_DELAY_MS=2, RANGE_BITS=2, TIMEOUT_MS=5, LFSR_SEED=16'hACE1.
- Reset: hold rst=0 for 5 cycles with start toggling -> all outputs 0, state=0; release -> remains IDLE.
- Normal trial: pulse start, bt=1 throughout -> WAIT 3 cycles after the start rise; w high for exactly 1 cycle after cur_delay*4 cycles (cur_delay in 2..5, checked against a reference LFSR model); press bt 10 cycles later -> done pulse, state=0.
- False start: start, then bt=0 after 2 cycles -> false_start=1, state=4, w never asserts. Pulse start while bt=0 -> stays in FAULT. Release bt, pulse start -> false_start=0, state=1, new cur_delay loaded.
- Timeout: start, never press -> w pulse, then after 20 cycles (5 ms x 4) one timeout pulse, state=0, done=0.
- Ignored and simultaneous events: start pulses during WAIT/HOLD change nothing. Force bt press in the exact cycle the delay expires -> FAULT, no w. Start with bt held in IDLE -> stays IDLE.
- Async reset mid-HOLD and mid-WAIT: outputs clear within the same cycle, no w afterwards; with TICK_DIV=1 and RANGE_BITS=11, 200 trials -> cur_delay always in 1000..3047 and never constant.

Source files
------------

// File: rtl/rtd_stimulus.sv
// rtl/rtd_stimulus.sv - reaction-time stimulus generator: random delay, w pulse, button supervision
module rtd_stimulus #(
    parameter int          TICK_DIV     = 100000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RANGE_BITS   = 11,
    parameter int          TIMEOUT_MS   = 2000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        bt,
    output logic        w,
    output logic        busy,
    output logic        false_start,
    output logic        done,
    output logic        timeout,
    output logic [15:0] cur_delay,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_FIRE  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0]   SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   MIN_V      = 16'(MIN_DELAY_MS);
    localparam logic [15:0]   TIMEOUT_V  = 16'(TIMEOUT_MS);

    if ((MIN_DELAY_MS + (1 << RANGE_BITS) - 1 > 65535) || (TIMEOUT_MS > 65535) ||
        (TICK_DIV < 1) || (RANGE_BITS < 1) || (RANGE_BITS > 16)) begin : g_param_check
        $error("rtd_stimulus: delay or timeout does not fit the 16-bit ms counter");
    end

    state_t        cur_st, nxt_st;
    logic          start_s1, start_s2, start_s3;
    logic          bt_s1, bt_s2;
    logic          start_rise, pressed;
    logic [15:0]   lfsr;
    logic [15:0]   rnd_ms;
    logic [PW-1:0] presc;
    logic [15:0]   ms_cnt, ms_inc;
    logic          tick, delay_hit, timeout_hit;
    logic          load_delay, done_nxt, timeout_nxt;

    // Two-flop synchronizers; start keeps one extra stage for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_s3 <= 1'b0;
            bt_s1    <= 1'b0;
            bt_s2    <= 1'b0;
        end else begin
            start_s1 <= start;
            start_s2 <= start_s1;
            start_s3 <= start_s2;
            bt_s1    <= bt;
            bt_s2    <= bt_s1;
        end
    end

    assign start_rise = start_s2 & ~start_s3;
    assign pressed    = ~bt_s2;

    // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1, stepping every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign rnd_ms = 16'(lfsr[RANGE_BITS-1:0]);

    assign tick        = (presc == PRESC_LAST);
    assign ms_inc      = (ms_cnt == 16'hFFFF) ? ms_cnt : ms_cnt + 16'd1;
    // Expiry is judged on the wrapping tick so N ms lasts exactly N*TICK_DIV cycles.
    assign delay_hit   = tick && (ms_inc >= cur_delay);
    assign timeout_hit = tick && (ms_inc >= TIMEOUT_V);

    // ms timebase, restarted from zero whenever the FSM changes state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc  <= '0;
            ms_cnt <= 16'd0;
        end else if (nxt_st != cur_st) begin
            presc  <= '0;
            ms_cnt <= 16'd0;
        end else if (tick) begin
            presc  <= '0;
            ms_cnt <= ms_inc;
        end else begin
            presc  <= presc + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st <= S_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // Next-state and event decode; a press always wins over a coincident expiry.
    always_comb begin
        nxt_st      = cur_st;
        load_delay  = 1'b0;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        case (cur_st)
            S_IDLE: begin
                if (start_rise && !pressed) begin
                    nxt_st     = S_WAIT;
                    load_delay = 1'b1;
                end
            end
            S_WAIT: begin
                if (pressed) begin
                    nxt_st = S_FAULT;
                end else if (delay_hit) begin
                    nxt_st = S_FIRE;
                end
            end
            S_FIRE: begin
                nxt_st = S_HOLD;
            end
            S_HOLD: begin
                if (pressed) begin
                    nxt_st   = S_IDLE;
                    done_nxt = 1'b1;
                end else if (timeout_hit) begin
                    nxt_st      = S_IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            S_FAULT: begin
                if (start_rise && !pressed) begin
                    nxt_st     = S_WAIT;
                    load_delay = 1'b1;
                end
            end
            default: begin
                nxt_st = S_IDLE;
            end
        endcase
    end

    // Registered, glitch-free outputs aligned with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w           <= 1'b0;
            false_start <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cur_delay   <= 16'd0;
        end else begin
            w           <= (nxt_st == S_FIRE);
            false_start <= (nxt_st == S_FAULT);
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            if (load_delay) begin
                cur_delay <= MIN_V + rnd_ms;
            end
        end
    end

    assign busy  = (cur_st == S_WAIT) || (cur_st == S_FIRE) || (cur_st == S_HOLD);
    assign state = cur_st;

endmodule

// File: tb/tb_rtd_stimulus.sv
// tb/tb_rtd_stimulus.sv - self-checking bench for rtd_stimulus with a behavioural trial model
module tb_rtd_stimulus;

    localparam int TD  = 4;
    localparam int MIN = 2;
    localparam int RB  = 2;
    localparam int TO  = 5;

    logic        clk = 1'b0;
    logic        rst, start, bt;
    logic        w, busy, false_start, done, timeout;
    logic [15:0] cur_delay;
    logic [2:0]  state;

    logic        rst2, start2, bt2;
    logic        w2, busy2, fs2, done2, to2;
    logic [15:0] cd2;
    logic [2:0]  state2;

    int n_checks = 0;
    int n_pass   = 0;
    int w_cnt    = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    rtd_stimulus #(.TICK_DIV(TD), .MIN_DELAY_MS(MIN), .RANGE_BITS(RB), .TIMEOUT_MS(TO),
                   .LFSR_SEED(16'hACE1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bt(bt), .w(w), .busy(busy),
        .false_start(false_start), .done(done), .timeout(timeout),
        .cur_delay(cur_delay), .state(state));

    rtd_stimulus #(.TICK_DIV(1), .MIN_DELAY_MS(1000), .RANGE_BITS(11), .TIMEOUT_MS(2000),
                   .LFSR_SEED(16'hACE1)) u_big (
        .clk(clk), .rst(rst2), .start(start2), .bt(bt2), .w(w2), .busy(busy2),
        .false_start(fs2), .done(done2), .timeout(to2),
        .cur_delay(cd2), .state(state2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(2);
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] target, input int max, input string name);
        int n = 0;
        while (state !== target && n < max) begin
            step(1);
            n++;
        end
        chk(name, 32'(state), 32'(target));
    endtask

    task automatic wait_w(input int max, input string name);
        int n = 0;
        while (w !== 1'b1 && n < max) begin
            step(1);
            n++;
        end
        chk(name, 32'(w), 32'd1);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Behavioural model: trial phase, cycles spent in the phase, and input history.
    int          m_mode, m_el, m_cd;
    logic [15:0] m_lfsr;
    logic [2:0]  m_hs, m_hb;
    logic        m_done, m_to;

    task automatic model_reset();
        m_mode = 0; m_el = 0; m_cd = 0; m_lfsr = 16'hACE1;
        m_hs = 3'b000; m_hb = 3'b000; m_done = 1'b0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic b);
        logic rise, prs;
        rise = m_hs[1] & ~m_hs[2];
        prs  = ~m_hb[1];
        m_done = 1'b0;
        m_to   = 1'b0;
        case (m_mode)
            0, 4: if (rise && !prs) begin
                m_cd = MIN + (int'(m_lfsr) % (1 << RB));
                m_mode = 1;
                m_el = 0;
            end
            1: begin
                m_el++;
                if (prs) m_mode = 4;
                else if (m_el == m_cd * TD) m_mode = 2;
            end
            2: begin
                m_mode = 3;
                m_el = 0;
            end
            3: begin
                m_el++;
                if (prs) begin m_done = 1'b1; m_mode = 0; end
                else if (m_el == TO * TD) begin m_to = 1'b1; m_mode = 0; end
            end
            default: m_mode = 0;
        endcase
        m_lfsr = lfsr_next(m_lfsr);
        m_hs = {m_hs[1:0], s};
        m_hb = {m_hb[1:0], b};
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        logic cap_s, cap_b, prev_rst;
        logic [31:0] act, exp;
        cap_s = 1'b0; cap_b = 1'b1; prev_rst = 1'b0;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst || !prev_rst) model_reset();
            else model_step(cap_s, cap_b);
            act = {8'd0, state, w, busy, false_start, done, timeout, cur_delay};
            exp = {8'd0, 3'(m_mode), (m_mode == 2), (m_mode >= 1 && m_mode <= 3),
                   (m_mode == 4), m_done, m_to, 16'(m_cd)};
            chk("cycle {state,w,busy,fs,done,to,cur_delay}", act, exp);
            if (w === 1'b1) w_cnt++;
            if (done === 1'b1) done_cnt++;
            cap_s = start; cap_b = bt; prev_rst = rst;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, cd, wc, dc, bmin, bmax;
        rst = 1'b0; start = 1'b0; bt = 1'b1;
        rst2 = 1'b0; start2 = 1'b0; bt2 = 1'b1;
        step(1);

        // Reset held with start toggling.
        for (int i = 0; i < 5; i++) begin
            start = ~start;
            step(1);
        end
        start = 1'b0;
        chk("reset state", 32'(state), 32'd0);
        chk("reset w/busy/fs/done/to", {27'd0, w, busy, false_start, done, timeout}, 32'd0);
        chk("reset cur_delay", 32'(cur_delay), 32'd0);
        rst = 1'b1;
        step(6);
        chk("idle after release", 32'(state), 32'd0);

        // Normal trial with a valid response.
        start = 1'b1;
        n = 0;
        while (state !== 3'd1 && n < 10) begin
            step(1);
            n++;
            if (n == 2) start = 1'b0;
        end
        start = 1'b0;
        chk("start latency", 32'(n), 32'd3);
        cd = int'(cur_delay);
        chk("cur_delay range 2..5", 32'(cd >= 2 && cd <= 5), 32'd1);
        n = 0;
        while (state === 3'd1 && n < 100) begin
            step(1);
            n++;
        end
        chk("wait length cycles", 32'(n), 32'(cd * 4));
        chk("w at fire", 32'(w), 32'd1);
        step(1);
        chk("w one cycle", 32'(w), 32'd0);
        chk("hold state", 32'(state), 32'd3);
        step(10);
        bt = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            step(1);
            n++;
        end
        chk("done pulse", 32'(done), 32'd1);
        chk("idle after done", 32'(state), 32'd0);
        bt = 1'b1;
        step(4);

        // False start, start while held, then recovery.
        wc = w_cnt;
        pulse_start();
        wait_state(3'd1, 10, "fs enter wait");
        step(2);
        bt = 1'b0;
        wait_state(3'd4, 10, "fs fault state");
        chk("fs flag", 32'(false_start), 32'd1);
        pulse_start();
        step(8);
        chk("fault kept with bt held", 32'(state), 32'd4);
        chk("no w in false start", 32'(w_cnt), 32'(wc));
        bt = 1'b1;
        step(4);
        pulse_start();
        wait_state(3'd1, 10, "fault recover wait");
        chk("fs cleared", 32'(false_start), 32'd0);
        wait_state(3'd0, 80, "recover trial ends");

        // Timeout.
        dc = done_cnt;
        pulse_start();
        wait_w(60, "timeout trial w");
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        chk("timeout distance", 32'(n), 32'd21);
        chk("timeout state idle", 32'(state), 32'd0);
        chk("no done on timeout", 32'(done_cnt), 32'(dc));
        step(3);

        // Start ignored in WAIT and HOLD.
        pulse_start();
        wait_state(3'd1, 10, "ign enter wait");
        step(1);
        pulse_start();
        chk("start ignored in wait", 32'(state), 32'd1);
        wait_w(60, "ign w");
        step(2);
        pulse_start();
        chk("start ignored in hold", 32'(state), 32'd3);
        wait_state(3'd0, 40, "ign trial ends");
        step(3);

        // Press lands on the exact cycle the delay expires.
        wc = w_cnt;
        pulse_start();
        wait_state(3'd1, 10, "coinc enter wait");
        cd = int'(cur_delay);
        step(cd * 4 - 3);
        bt = 1'b0;
        wait_state(3'd4, 10, "coinc fault");
        chk("coinc no w", 32'(w_cnt), 32'(wc));
        bt = 1'b1;
        step(4);
        pulse_start();
        wait_state(3'd0, 80, "coinc recover ends");

        // Start with bt held in IDLE.
        bt = 1'b0;
        step(3);
        pulse_start();
        step(6);
        chk("start with press ignored", 32'(state), 32'd0);
        bt = 1'b1;
        step(3);

        // Async reset mid-HOLD and mid-WAIT.
        pulse_start();
        wait_w(60, "rst hold w");
        step(3);
        rst = 1'b0;
        #1;
        chk("rst hold outputs", {8'd0, state, w, busy, false_start, done, timeout, cur_delay}, 32'd0);
        step(2);
        rst = 1'b1;
        wc = w_cnt;
        step(40);
        chk("no w after hold reset", 32'(w_cnt), 32'(wc));
        pulse_start();
        wait_state(3'd1, 10, "rst wait enter");
        step(2);
        rst = 1'b0;
        #1;
        chk("rst wait outputs", {8'd0, state, w, busy, false_start, done, timeout, cur_delay}, 32'd0);
        step(2);
        rst = 1'b1;
        wc = w_cnt;
        step(40);
        chk("no w after wait reset", 32'(w_cnt), 32'(wc));

        // Randomized activity, checked cycle by cycle by the model.
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 25));
            case ($urandom_range(0, 2))
                0: pulse_start();
                1: begin
                    bt = 1'b0;
                    step($urandom_range(1, 6));
                    bt = 1'b1;
                end
                default: begin
                    bt = 1'($urandom_range(0, 1));
                    start = 1'b1;
                    step($urandom_range(1, 4));
                    start = 1'b0;
                    bt = 1'b1;
                end
            endcase
        end
        start = 1'b0;
        bt = 1'b1;
        step(60);

        // Full-range delays: 200 trials cycled through WAIT and FAULT.
        rst2 = 1'b1;
        step(3);
        bmin = 65535;
        bmax = 0;
        for (int t = 0; t < 200; t++) begin
            start2 = 1'b1;
            step(2);
            start2 = 1'b0;
            n = 0;
            while (state2 !== 3'd1 && n < 10) begin
                step(1);
                n++;
            end
            chk("big wait entry", 32'(state2), 32'd1);
            chk("big cur_delay 1000..3047", 32'(cd2 >= 16'd1000 && cd2 <= 16'd3047), 32'd1);
            if (int'(cd2) < bmin) bmin = int'(cd2);
            if (int'(cd2) > bmax) bmax = int'(cd2);
            bt2 = 1'b0;
            n = 0;
            while (state2 !== 3'd4 && n < 10) begin
                step(1);
                n++;
            end
            chk("big fault", 32'(state2), 32'd4);
            bt2 = 1'b1;
            step(3 + $urandom_range(0, 3));
        end
        chk("big cur_delay varies", 32'(bmax > bmin), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
